// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Central stall/flush sequencer for a 5-stage pipeline. It drives the
//   enable and flush controls of the PC and of the IF/ID, ID/EX, EX/MEM and
//   MEM/WB pipeline registers.
//
//   Conditions handled, highest priority first:
//     ERR          memory timeout; the pipeline stays frozen until reset
//     memory wait  data-memory req/ready handshake not yet complete
//     branch       taken branch/jump in EX squashes IF/ID and ID/EX
//     load-use     inserts one bubble behind a load whose result ID needs
//
//   All enable and flush outputs are combinational, so they take effect in
//   the same cycle. The FSM state, wait counter, error flag and stall counter
//   are registered.
//
// Ports
//   clk, rst            clock, synchronous active-low reset
//   id_rs, id_rt        source register fields of the ID instruction
//   id_uses_rt          the ID instruction reads rt
//   ex_MemRead, ex_WN   the EX instruction is a load, and its destination
//   ex_branch_taken     branch/jump in EX resolved taken
//   mem_MemRead/Write   the MEM instruction accesses data memory
//   dmem_ready          data memory completes the access this cycle
//   dmem_req            data-memory request
//   en_*                pipeline register / PC enables
//   flush_ifid/idex     bubble insertion into IF/ID and ID/EX
//   mem_timeout         sticky timeout error flag
//   stall_cycles        saturating count of stall/bubble cycles
module pipe_hazard_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_MemRead,
  input  logic [4:0]       ex_WN,
  input  logic             ex_branch_taken,
  input  logic             mem_MemRead,
  input  logic             mem_MemWrite,
  input  logic             dmem_ready,
  output logic             dmem_req,
  output logic             en_pc,
  output logic             en_ifid,
  output logic             en_idex,
  output logic             en_exmem,
  output logic             en_memwb,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int WC_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WC_W-1:0] TIMEOUT_CNT = WC_W'(TIMEOUT);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_ERR      = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic             mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

  logic mem_acc;
  logic load_use;
  logic freeze;
  logic in_err;
  logic bubble;
  logic req_c;

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign mem_acc  = mem_MemRead | mem_MemWrite;
  assign load_use = ex_MemRead & (ex_WN != 5'd0) &
                    ((ex_WN == id_rs) | (id_uses_rt & (ex_WN == id_rt)));

  // Next-state logic for the handshake FSM
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    freeze        = 1'b0;
    in_err        = 1'b0;
    req_c         = 1'b0;
    unique case (state_q)
      S_RUN: begin
        if (mem_acc) begin
          req_c = 1'b1;
          // The first cycle of an access that is not ready already freezes
          // and counts as wait cycle 1.
          if (!dmem_ready) begin
            freeze     = 1'b1;
            state_d    = S_MEM_WAIT;
            wait_cnt_d = WC_W'(1);
          end
        end
      end
      S_MEM_WAIT: begin
        req_c = 1'b1;
        if (dmem_ready) begin
          state_d    = S_RUN;
          wait_cnt_d = '0;
        end else begin
          freeze = 1'b1;
          if (wait_cnt_q == TIMEOUT_CNT) begin
            state_d       = S_ERR;
            mem_timeout_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + WC_W'(1);
          end
        end
      end
      S_ERR: begin
        in_err        = 1'b1;
        mem_timeout_d = 1'b1;
      end
      default: begin
        state_d    = S_RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  // A branch squashes the ID instruction, so a coincident load-use is moot.
  // Hazards seen during a freeze are re-evaluated on the release cycle since
  // the pipeline contents have not moved.
  assign bubble = ~in_err & ~freeze & ~ex_branch_taken & load_use;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (freeze | in_err | bubble) begin
      stall_cycles_d = sat_inc(stall_cycles_q);
    end
  end

  // Pipeline control outputs; reset overrides everything, even mid-access
  always_comb begin
    dmem_req   = req_c;
    en_pc      = 1'b1;
    en_ifid    = 1'b1;
    en_idex    = 1'b1;
    en_exmem   = 1'b1;
    en_memwb   = 1'b1;
    flush_ifid = 1'b0;
    flush_idex = 1'b0;
    if (!rst) begin
      dmem_req = 1'b0;
      en_pc    = 1'b0;
      en_ifid  = 1'b0;
      en_idex  = 1'b0;
      en_exmem = 1'b0;
      en_memwb = 1'b0;
    end else if (in_err | freeze) begin
      en_pc    = 1'b0;
      en_ifid  = 1'b0;
      en_idex  = 1'b0;
      en_exmem = 1'b0;
      en_memwb = 1'b0;
    end else if (ex_branch_taken) begin
      flush_ifid = 1'b1;
      flush_idex = 1'b1;
    end else if (load_use) begin
      en_pc      = 1'b0;
      en_ifid    = 1'b0;
      flush_idex = 1'b1;
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= S_RUN;
      wait_cnt_q     <= '0;
      mem_timeout_q  <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      mem_timeout_q  <= mem_timeout_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign mem_timeout  = mem_timeout_q;
  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: table-driven single-cycle vectors plus
// hand-written multi-cycle sequences, checked through an expectation queue.
module tb_pipe_hazard_ctrl;

  localparam int TIMEOUT = 8;
  localparam int CNT_W   = 4;

  // Output order: {dmem_req, en_pc, en_ifid, en_idex, en_exmem, en_memwb,
  //                flush_ifid, flush_idex}
  localparam logic [7:0] O_RST = 8'b0000_0000;
  localparam logic [7:0] O_RUN = 8'b0111_1100;
  localparam logic [7:0] O_LU  = 8'b0001_1101;
  localparam logic [7:0] O_BR  = 8'b0111_1111;
  localparam logic [7:0] O_FRZ = 8'b1000_0000;
  localparam logic [7:0] O_MEM = 8'b1111_1100;
  localparam logic [7:0] O_MLU = 8'b1001_1101;
  localparam logic [7:0] O_MBR = 8'b1111_1111;
  localparam logic [7:0] O_ERR = 8'b0000_0000;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       id_rs, id_rt, ex_WN;
  logic             id_uses_rt, ex_MemRead, ex_branch_taken;
  logic             mem_MemRead, mem_MemWrite, dmem_ready;
  logic             dmem_req, en_pc, en_ifid, en_idex, en_exmem, en_memwb;
  logic             flush_ifid, flush_idex, mem_timeout;
  logic [CNT_W-1:0] stall_cycles;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_MemRead(ex_MemRead), .ex_WN(ex_WN), .ex_branch_taken(ex_branch_taken),
    .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite),
    .dmem_ready(dmem_ready), .dmem_req(dmem_req),
    .en_pc(en_pc), .en_ifid(en_ifid), .en_idex(en_idex),
    .en_exmem(en_exmem), .en_memwb(en_memwb),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex),
    .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
  );

  typedef struct {
    logic       r;
    logic [4:0] rs, rt;
    logic       urt, exr;
    logic [4:0] wn;
    logic       br, mrd, mwr, rdy;
    logic [7:0] exp;
    logic       to;
    logic       inc;
  } vec_t;

  typedef struct {
    logic [7:0] outs;
    logic       to;
    logic       inc;
    logic       r;
    int         tag;
  } exp_t;

  exp_t             sb[$];
  vec_t             tbl[$];
  logic [CNT_W-1:0] exp_stall;
  int               ncmp = 0;
  int               nfail = 0;
  string            phase = "init";
  int               step_no = 0;

  function automatic vec_t mk(input logic r, input logic [4:0] rs, rt,
                              input logic urt, exr, input logic [4:0] wn,
                              input logic br, mrd, mwr, rdy,
                              input logic [7:0] e, input logic to, inc);
    vec_t v;
    v.r = r; v.rs = rs; v.rt = rt; v.urt = urt; v.exr = exr; v.wn = wn;
    v.br = br; v.mrd = mrd; v.mwr = mwr; v.rdy = rdy;
    v.exp = e; v.to = to; v.inc = inc;
    return v;
  endfunction

  task automatic check();
    exp_t       e;
    logic [7:0] got;
    if (sb.size() == 0) begin
      ncmp++; nfail++;
      $display("FAIL %s#%0d scoreboard empty", phase, step_no);
      return;
    end
    e   = sb.pop_front();
    got = {dmem_req, en_pc, en_ifid, en_idex, en_exmem, en_memwb,
           flush_ifid, flush_idex};
    ncmp++;
    if (got !== e.outs) begin
      nfail++;
      $display("FAIL %s#%0d outs got %b want %b", phase, e.tag, got, e.outs);
    end
    ncmp++;
    if (mem_timeout !== e.to) begin
      nfail++;
      $display("FAIL %s#%0d mem_timeout got %b want %b", phase, e.tag,
               mem_timeout, e.to);
    end
    ncmp++;
    if (stall_cycles !== exp_stall) begin
      nfail++;
      $display("FAIL %s#%0d stall_cycles got %0d want %0d", phase, e.tag,
               stall_cycles, exp_stall);
    end
    // Expected counter value after the coming clock edge
    if (!e.r) exp_stall = '0;
    else if (e.inc && exp_stall != 4'hF) exp_stall = exp_stall + 4'd1;
  endtask

  task automatic drive(input vec_t v);
    exp_t e;
    rst = v.r; id_rs = v.rs; id_rt = v.rt; id_uses_rt = v.urt;
    ex_MemRead = v.exr; ex_WN = v.wn; ex_branch_taken = v.br;
    mem_MemRead = v.mrd; mem_MemWrite = v.mwr; dmem_ready = v.rdy;
    e.outs = v.exp; e.to = v.to; e.inc = v.inc; e.r = v.r; e.tag = step_no;
    sb.push_back(e);
    @(negedge clk);
    check();
    step_no++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; id_rs = '0; id_rt = '0; id_uses_rt = 1'b0; ex_MemRead = 1'b0;
    ex_WN = '0; ex_branch_taken = 1'b0; mem_MemRead = 1'b0;
    mem_MemWrite = 1'b0; dmem_ready = 1'b0;
    exp_stall = '0;
    @(posedge clk);
    #1;

    // Reset with a pending access, then single-cycle RUN vectors
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0,0,0,0,0,0,0,1,0,0,O_RST,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0,O_RUN,0,0)); // RUN after reset
    tbl.push_back(mk(1,5,0,0,1,5,0,0,0,1,O_LU ,0,1)); // load-use on rs
    tbl.push_back(mk(1,0,0,0,1,0,0,0,0,1,O_RUN,0,0)); // WN=0 never stalls
    tbl.push_back(mk(1,4,0,1,1,0,0,0,0,1,O_RUN,0,0)); // WN=0 via rt
    tbl.push_back(mk(1,3,7,1,1,7,0,0,0,1,O_LU ,0,1)); // load-use on rt
    tbl.push_back(mk(1,3,7,0,1,7,0,0,0,1,O_RUN,0,0)); // rt not a source
    tbl.push_back(mk(1,5,0,0,0,5,0,0,0,1,O_RUN,0,0)); // not a load
    tbl.push_back(mk(1,5,0,0,1,5,1,0,0,1,O_BR ,0,0)); // branch beats load-use
    tbl.push_back(mk(1,0,0,0,0,0,1,0,0,1,O_BR ,0,0)); // branch alone
    tbl.push_back(mk(1,0,0,0,0,0,0,0,1,1,O_MEM,0,0)); // store ready at once
    tbl.push_back(mk(1,5,0,0,1,5,0,1,0,1,O_MLU,0,1)); // ready load + load-use
    tbl.push_back(mk(1,0,0,0,0,0,1,1,0,1,O_MBR,0,0)); // ready load + branch
    phase = "table";
    for (int i = 0; i < tbl.size(); i++) drive(tbl[i]);

    // Four-cycle memory wait; hazards during the freeze are ignored
    phase = "memwait";
    drive(mk(1,0,0,0,0,0,0,1,0,0,O_FRZ,0,1));
    drive(mk(1,0,0,0,0,0,1,1,0,0,O_FRZ,0,1));
    drive(mk(1,5,0,0,1,5,0,1,0,0,O_FRZ,0,1));
    drive(mk(1,0,0,0,0,0,0,1,0,0,O_FRZ,0,1));
    drive(mk(1,0,0,0,0,0,0,1,0,1,O_MEM,0,0));
    drive(mk(1,0,0,0,0,0,0,0,0,0,O_RUN,0,0));

    // Release cycle re-evaluates load-use, then branch+load-use
    phase = "release";
    drive(mk(1,0,0,0,0,0,0,1,0,0,O_FRZ,0,1));
    drive(mk(1,5,0,0,1,5,0,1,0,1,O_MLU,0,1));
    drive(mk(1,0,0,0,0,0,0,0,1,0,O_FRZ,0,1));
    drive(mk(1,5,0,0,1,5,1,0,1,1,O_MBR,0,0));

    // Reset in the middle of an access
    phase = "midrst";
    drive(mk(1,0,0,0,0,0,0,1,0,0,O_FRZ,0,1));
    drive(mk(0,0,0,0,0,0,0,1,0,0,O_RST,0,0));
    drive(mk(1,0,0,0,0,0,0,0,0,0,O_RUN,0,0));

    // Timeout: entry + TIMEOUT wait cycles frozen, then ERR until reset
    phase = "timeout";
    for (int i = 0; i <= TIMEOUT; i++) drive(mk(1,0,0,0,0,0,0,1,0,0,O_FRZ,0,1));
    for (int i = 0; i < 3; i++) drive(mk(1,0,0,0,0,0,0,1,0,0,O_ERR,1,1));
    drive(mk(1,0,0,0,0,0,1,1,0,1,O_ERR,1,1));
    drive(mk(1,5,0,0,1,5,0,0,0,1,O_ERR,1,1));
    for (int i = 0; i < 3; i++) drive(mk(1,0,0,0,0,0,0,0,0,0,O_ERR,1,1));
    drive(mk(0,0,0,0,0,0,0,0,0,0,O_RST,1,0));
    drive(mk(1,0,0,0,0,0,0,0,0,0,O_RUN,0,0));

    // Saturation of the stall counter under a continuous load-use stall
    phase = "sat";
    for (int i = 0; i < 20; i++) drive(mk(1,5,0,0,1,5,0,0,0,1,O_LU,0,1));
    drive(mk(1,0,0,0,0,0,0,0,0,1,O_RUN,0,0));
    drive(mk(1,0,0,0,0,0,0,0,0,1,O_RUN,0,0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
